// File: rtl/mem_to_fifo_pkg.sv
// Shared constants and helpers for the dflow replay engine and
// the FIFO-to-memory store path.
package mem_to_fifo_pkg;

    localparam int DEF_ADDR_W  = 19;
    localparam int DEF_DATA_W  = 144;
    localparam int DEF_MAX_OUT = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/mem_to_fifo_if.sv
// Memory read port, generator FIFO push port, control and status
// of the replay engine.
interface mem_to_fifo_if #(
    parameter int AW = 19,
    parameter int DW = 144
);
    logic          app_rd_cmd;
    logic [AW-1:0] app_rd_addr;
    logic          app_rd_valid;
    logic [DW-1:0] app_rd_data;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_data;
    logic          fifo_full;
    logic [AW-1:0] dflow_addr_low;
    logic [AW-1:0] dflow_mem_high;
    logic          start_replay;
    logic          loop_en;
    logic          cal_done;
    logic          sw_rst;
    logic          replay_busy;
    logic          replay_done;
    logic [31:0]   replay_words;

    modport master (
        output app_rd_cmd, app_rd_addr,
        output fifo_wr_en, fifo_data,
        output replay_busy, replay_done, replay_words,
        input  app_rd_valid, app_rd_data, fifo_full,
        input  dflow_addr_low, dflow_mem_high,
        input  start_replay, loop_en, cal_done, sw_rst
    );

    modport slave (
        input  app_rd_cmd, app_rd_addr,
        input  fifo_wr_en, fifo_data,
        input  replay_busy, replay_done, replay_words,
        output app_rd_valid, app_rd_data, fifo_full,
        output dflow_addr_low, dflow_mem_high,
        output start_replay, loop_en, cal_done, sw_rst
    );

endinterface

// File: rtl/mem_to_fifo_rd_return_buf.sv
// First-word-fall-through return buffer; the head is visible on
// rd_data whenever the buffer is not empty.
module rd_return_buf
    import mem_to_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 144
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic [clog2(DEPTH+1)-1:0]    count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q;
    logic [AW-1:0]    rp_q;
    logic [CW-1:0]    cnt_q;
    logic             do_rd;

    assign do_rd   = rd_en & (cnt_q != '0);
    assign rd_data = mem_q[rp_q];
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wp_q] <= wr_data;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wp_q <= wp_q + AW'(1);
            if (do_rd) rp_q <= rp_q + AW'(1);
            if (wr_en & ~do_rd)
                cnt_q <= cnt_q + CW'(1);
            else if (~wr_en & do_rd)
                cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/mem_to_fifo.sv
// Replays the stored dflow region from memory into the generator
// FIFO, issuing reads only against free return-buffer credit.
module mem_to_fifo
    import mem_to_fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = DEF_DATA_W,
    parameter int MEM_ADDR_WIDTH  = DEF_ADDR_W,
    parameter int MEM_DATA_WIDTH  = DEF_DATA_W,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUT
) (
    input logic           clk,
    input logic           rst,
    mem_to_fifo_if.master bus
);

    localparam int AW = MEM_ADDR_WIDTH;
    localparam int CW = clog2(MAX_OUTSTANDING + 1);
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [CW:0] CRED_MAX = (CW+1)'(MAX_OUTSTANDING);

    logic                      clr;
    logic [1:0]                state_q, state_d;
    logic [AW-1:0]             ptr_q, ptr_d;
    logic [AW-1:0]             lo_q, lo_d;
    logic [AW-1:0]             hi_q, hi_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic                      cmd_q, cmd_d;
    logic [CW-1:0]             outst_q, outst_d;
    logic [31:0]               words_q, words_d;
    logic [CW-1:0]             buf_count;
    logic                      buf_empty;
    logic [MEM_DATA_WIDTH-1:0] buf_head;
    logic [CW:0]               credit_used;
    logic                      issue;
    logic                      accept;
    logic                      pop;

    assign clr = rst | bus.sw_rst;

    // Credit covers both in-flight reads and words parked in the buffer.
    assign credit_used = {1'b0, outst_q} + {1'b0, buf_count};
    assign issue = (state_q == ST_ISSUE) & bus.start_replay
                 & bus.cal_done & (credit_used < CRED_MAX);
    assign accept = bus.app_rd_valid & (outst_q != '0);
    assign pop    = ~buf_empty & ~bus.fifo_full;

    rd_return_buf #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (MEM_DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (clr),
        .wr_en   (accept),
        .wr_data (bus.app_rd_data),
        .rd_en   (pop),
        .rd_data (buf_head),
        .empty   (buf_empty),
        .count   (buf_count)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_replay & bus.cal_done) begin
                    lo_d  = bus.dflow_addr_low;
                    hi_d  = bus.dflow_mem_high;
                    ptr_d = bus.dflow_addr_low;
                    if (bus.dflow_mem_high != bus.dflow_addr_low)
                        state_d = ST_ISSUE;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (!bus.start_replay) begin
                    state_d = ST_DRAIN;
                end else if (issue) begin
                    if (ptr_q == hi_q - ONE) begin
                        if (bus.loop_en) ptr_d = lo_q;
                        else state_d = ST_DRAIN;
                    end else begin
                        ptr_d = ptr_q + ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if ((outst_q == '0) && buf_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.start_replay) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_d   = issue;
        addr_d  = issue ? ptr_q : addr_q;
        words_d = pop ? words_q + 32'd1 : words_q;
        outst_d = outst_q;
        if (issue & ~accept)
            outst_d = outst_q + CW'(1);
        else if (~issue & accept)
            outst_d = outst_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            cmd_q   <= 1'b0;
            outst_q <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            outst_q <= outst_d;
            words_q <= words_d;
        end
    end

    logic [FIFO_DATA_WIDTH-1:0] head_out;
    assign head_out = buf_empty ? '0 : buf_head;

    assign bus.app_rd_cmd   = cmd_q;
    assign bus.app_rd_addr  = addr_q;
    assign bus.fifo_wr_en   = pop;
    assign bus.fifo_data    = head_out;
    assign bus.replay_busy  = (state_q == ST_ISSUE) | (state_q == ST_DRAIN);
    assign bus.replay_done  = (state_q == ST_DONE);
    assign bus.replay_words = words_q;

endmodule
